// File: rtl/ahb3lite_mem_slave.sv
// AHB3-Lite on-chip memory slave: byte-lane writes, optional wait states,
// two-cycle ERROR response for bad size, misalignment or out-of-range address.
module ahb3lite_mem_slave #(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int NB = HDATA_SIZE / 8;
  localparam int AB = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [HADDR_SIZE-1:0] r_addr;
  logic                  r_write;
  logic [2:0]            r_size;
  logic                  r_hready;
  logic                  r_hresp;
  logic [HDATA_SIZE-1:0] r_mem [MEM_DEPTH];

  logic                  w_accept;
  logic                  w_err;
  logic [AB-1:0]         w_lo_mask;
  logic [HADDR_SIZE-1:0] w_word;
  logic [NB-1:0]         w_be;
  logic [IW-1:0]         w_idx;
  logic                  w_unused;

  // HTRANS[1] set means NONSEQ or SEQ
  assign w_accept  = HSEL & HREADY & HTRANS[1];
  assign w_lo_mask = AB'((32'd1 << HSIZE) - 32'd1);
  assign w_word    = HADDR >> AB;
  assign w_err     = (HSIZE > 3'(AB)) | (|(HADDR[AB-1:0] & w_lo_mask)) |
                     (w_word >= HADDR_SIZE'(MEM_DEPTH));
  assign w_idx     = r_addr[AB +: IW];
  assign w_unused  = ^{HBURST, HPROT, HMASTLOCK, r_addr >> (AB + IW)};

  always_comb begin
    w_be = '0;
    for (int b = 0; b < NB; b++)
      w_be[b] = ((AB'(b) >> r_size) == (r_addr[AB-1:0] >> r_size));
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_size   <= '0;
      r_hready <= 1'b1;
      r_hresp  <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == CW'(WAIT_STATES - 1)) begin
            r_state  <= S_DATA;
            r_cnt    <= '0;
            r_hready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= 1'b1;
        end
        default: begin
          if (w_accept) begin
            r_addr  <= HADDR;
            r_write <= HWRITE;
            r_size  <= HSIZE;
            r_cnt   <= '0;
            if (w_err) begin
              r_state  <= S_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              r_state  <= S_WAIT;
              r_hready <= 1'b0;
              r_hresp  <= 1'b0;
            end else begin
              r_state  <= S_DATA;
              r_hready <= 1'b1;
              r_hresp  <= 1'b0;
            end
          end else begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Storage is never reset; a write is dropped if reset lands on its final edge
  always_ff @(posedge HCLK) begin
    if (HRESETn && r_state == S_DATA && r_write)
      for (int b = 0; b < NB; b++)
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= HWDATA[b*8 +: 8];
  end

  assign HRDATA    = (r_state == S_DATA && !r_write) ? r_mem[w_idx] : '0;
  assign HREADYOUT = r_hready;
  assign HRESP     = r_hresp;
endmodule

// File: doc/ahb3lite_mem_slave.md
AHB3LITE_MEM_SLAVE -- requirements
Module: ahb3lite_mem_slave

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 16: AHB address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32: AHB data width, 32 or 64.
REQ-003 SHALL have parameter MEM_DEPTH, default 256: number of HDATA_SIZE-bit words, power of 2.
REQ-004 SHALL have parameter WAIT_STATES, default 0: wait cycles inserted per OKAY transfer, 0..15.
REQ-005 SHALL use one clock, HCLK; reset is HRESETn, synchronous and active-low.
REQ-006 Ports, in this order:
- HCLK  in  1  clock
- HRESETn  in  1  synchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  address
- HWDATA  in  HDATA_SIZE  write data
- HRDATA  out  HDATA_SIZE  read data
- HWRITE  in  1  1=write
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type, ignored
- HPROT  in  4  protection, ignored
- HTRANS  in  2  transfer type
- HMASTLOCK  in  1  lock, ignored
- HREADY  in  1  bus ready (previous data phase done)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR

Function
REQ-007 Address phase SHALL be accepted only when HSEL=1, HREADY=1 and HTRANS is NONSEQ (2) or SEQ (3) at a rising HCLK edge; HADDR, HWRITE and HSIZE are latched on acceptance.
REQ-008 IDLE/BUSY HTRANS, or HSEL=0 with HREADY=1, SHALL give a zero-wait OKAY response and change no memory.
REQ-009 An accepted transfer SHALL be an error if HSIZE > log2(HDATA_SIZE/8), if HADDR is not aligned to HSIZE, or if HADDR >> log2(HDATA_SIZE/8) >= MEM_DEPTH.
REQ-010 FSM states SHALL be IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-011 From IDLE, DATA or ERR2, acceptance SHALL go to:
- ERR1 if the transfer is an error;
- otherwise WAIT if WAIT_STATES>0, else DATA.
Without acceptance these states SHALL go to IDLE.
REQ-012 WAIT SHALL last exactly WAIT_STATES cycles, counted by a $clog2(WAIT_STATES+1)-bit counter, then go to DATA.
REQ-013 ERR1 SHALL always go to ERR2.
REQ-014 Outputs per state:
- IDLE and DATA: HREADYOUT=1, HRESP=0.
- WAIT: HREADYOUT=0, HRESP=0.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
REQ-015 Read in DATA SHALL drive HRDATA = mem[latched word index] combinationally; HRDATA SHALL be 0 in all other states and for writes.
REQ-016 Write in DATA SHALL update only the byte lanes selected by latched HSIZE and HADDR low bits with HWDATA, at the clock edge ending DATA.
REQ-017 A read immediately following a write to the same word SHALL return the newly written data.
REQ-018 Error transfers SHALL not modify memory.
REQ-019 Back-to-back pipelined transfers SHALL be supported: a new address phase accepted in DATA or ERR2 proceeds per REQ-011 with no idle cycle.
REQ-020 HBURST, HPROT and HMASTLOCK SHALL not affect behaviour; each burst beat is an independent transfer.

Reset
REQ-021 While HRESETn=0 at a rising edge, the block SHALL go to IDLE with the wait counter at 0 and latched control cleared, giving HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-022 Memory contents SHALL not be reset.
REQ-023 Reset during WAIT, DATA, ERR1 or ERR2 SHALL abort the transfer; a pending write SHALL be discarded.

Verification
REQ-024 Reset: HRESETn=0 for 2 cycles, then 1 -> HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-025 WAIT_STATES=0: write 0xDEADBEEF at 0x0010, then read 0x0010 back-to-back -> HRDATA=0xDEADBEEF; HREADYOUT never 0.
REQ-026 Byte lane: word write 0x11223344 at 0x0010, byte write (HSIZE=0) at 0x0011 with HWDATA=0x0000AB00, word read 0x0010 -> 0x1122AB44.
REQ-027 WAIT_STATES=2: read -> HREADYOUT=0 for exactly 2 cycles, then 1 with HRESP=0 and valid HRDATA.
REQ-028 Error, MEM_DEPTH=256: write at 0x0400, or halfword at 0x0013 -> HREADYOUT=0/HRESP=1 for one cycle, then HREADYOUT=1/HRESP=1; a later read of the targeted word is unchanged.
REQ-029 Reset mid-transfer: HRESETn=0 during WAIT of a write to 0x0020 -> next cycle HREADYOUT=1, HRESP=0; a later read of 0x0020 returns the prior value.
